// File: rtl/debug_display.sv
`default_nettype none
// ============================================================================
//  Module      : debug_display
//  Description : Board debug front end for the mips core. Debounces two
//                push-buttons that step the checka register-index selector,
//                and scans a snapshotted 32-bit word onto an 8-digit
//                multiplexed active-low 7-segment display.
//  Revision    : 1.0  initial release
// ============================================================================
module debug_display #(
    parameter int N               = 32,
    parameter int DIGIT_CYCLES    = 50000,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [7:0]   pclow,
    input  logic [4:0]   state,
    input  logic [N-1:0] check,
    output logic [4:0]   checka,
    input  logic         btn_up,
    input  logic         btn_down,
    input  logic         sw_mode,
    output logic [7:0]   an,
    output logic [6:0]   seg,
    output logic         dp
);

    localparam int DIV_W = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
    localparam int DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIGIT_CYCLES - 1);
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);

    // Bit order of the synchronizer vectors: {sw_mode, btn_down, btn_up}
    logic [2:0] meta_q;
    logic [2:0] sync_q;
    logic [1:0] btn_pulse;   // [0] = up, [1] = down

    logic [4:0]       checka_q, checka_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [2:0]       idx_q, idx_d;
    logic [31:0]      shadow_q, shadow_d;
    logic             mode_q, mode_d;
    logic [31:0]      word;
    logic [3:0]       nibble;
    logic [7:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;
    logic             dp_q, dp_d;

    // Segment pattern for one hex digit, {g,f,e,d,c,b,a} active-low
    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
            4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
            4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
            4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // Two-flop synchronizers for the asynchronous button and switch inputs
    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= 3'b000;
            sync_q <= 3'b000;
        end else begin
            meta_q <= {sw_mode, btn_down, btn_up};
            sync_q <= meta_q;
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_debounce
        logic [DB_W-1:0] cnt_q, cnt_d;
        logic            lvl_q, lvl_d;
        logic            pulse_q, pulse_d;

        // Count consecutive disagreeing samples; flip the level on the last one
        always_comb begin
            cnt_d   = '0;
            lvl_d   = lvl_q;
            pulse_d = 1'b0;
            if (sync_q[b] != lvl_q) begin
                if (cnt_q == DB_LAST) begin
                    lvl_d   = ~lvl_q;
                    pulse_d = ~lvl_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end

        // Debounce state register; reset discards any half-counted press
        always_ff @(posedge clk) begin
            if (reset) begin
                cnt_q   <= '0;
                lvl_q   <= 1'b0;
                pulse_q <= 1'b0;
            end else begin
                cnt_q   <= cnt_d;
                lvl_q   <= lvl_d;
                pulse_q <= pulse_d;
            end
        end

        assign btn_pulse[b] = pulse_q;
    end

    // Step the register index; simultaneous up and down cancel
    always_comb begin
        checka_d = checka_q;
        case (btn_pulse)
            2'b01:   checka_d = checka_q + 5'd1;
            2'b10:   checka_d = checka_q - 5'd1;
            default: checka_d = checka_q;
        endcase
    end

    // Word to be captured at the next frame boundary
    always_comb begin
        word = sync_q[2] ? {pclow, 3'b000, state, 3'b000, checka_q, check[7:0]}
                         : check[31:0];
    end

    // Digit scan: divider, digit index and the once-per-frame snapshot
    always_comb begin
        div_d    = div_q + 1'b1;
        idx_d    = idx_q;
        shadow_d = shadow_q;
        mode_d   = mode_q;
        if (div_q == DIV_LAST) begin
            div_d = '0;
            idx_d = idx_q + 3'd1;
            if (idx_q == 3'd7) begin
                shadow_d = word;
                mode_d   = sync_q[2];
            end
        end
    end

    // Output decode of the current digit from the frozen snapshot
    always_comb begin
        nibble = shadow_q[{idx_q, 2'b00} +: 4];
        an_d   = ~(8'b1 << idx_q);
        seg_d  = hex7(nibble);
        dp_d   = ~((idx_q == 3'd4) && !mode_q);
    end

    // Selector, scan state and registered display outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            checka_q <= 5'd0;
            div_q    <= '0;
            idx_q    <= 3'd0;
            shadow_q <= 32'd0;
            mode_q   <= 1'b0;
            an_q     <= 8'hFE;
            seg_q    <= 7'h40;
            dp_q     <= 1'b1;
        end else begin
            checka_q <= checka_d;
            div_q    <= div_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            mode_q   <= mode_d;
            an_q     <= an_d;
            seg_q    <= seg_d;
            dp_q     <= dp_d;
        end
    end

    assign checka = checka_q;
    assign an     = an_q;
    assign seg    = seg_q;
    assign dp     = dp_q;

endmodule
`default_nettype wire
